// File: rtl/rsa_core_exp_if.sv
// Handshake bundle for the modular exponentiation controller.
// It carries the request/result side and the downstream mod-core side.
interface rsa_core_exp_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    exp_start;
    logic [DATA_WIDTH-1:0]   exp_base;
    logic [DATA_WIDTH-1:0]   exp_e;
    logic [DATA_WIDTH-1:0]   exp_n;
    logic                    exp_busy;
    logic                    exp_done;
    logic                    exp_err;
    logic [DATA_WIDTH-1:0]   exp_c;
    logic                    mod_start;
    logic [2*DATA_WIDTH-1:0] mod_a;
    logic [DATA_WIDTH-1:0]   mod_b;
    logic                    mod_done;
    logic                    mod_err;
    logic [DATA_WIDTH-1:0]   mod_c;

    // master is the exponentiation core: it issues mod requests and reports results
    modport master (
        input  exp_start, exp_base, exp_e, exp_n, mod_done, mod_err, mod_c,
        output exp_busy, exp_done, exp_err, exp_c, mod_start, mod_a, mod_b
    );

    modport slave (
        output exp_start, exp_base, exp_e, exp_n, mod_done, mod_err, mod_c,
        input  exp_busy, exp_done, exp_err, exp_c, mod_start, mod_a, mod_b
    );
endinterface

// File: rtl/rsa_core_exp.sv
// MSB-first square-and-multiply controller computing base^E mod N
// through an external reduction core, one outstanding request at a time.
module rsa_core_exp #(
    parameter int   DATA_WIDTH = 8,
    parameter logic START      = 1'b1
) (
    input  logic           exp_clk,
    input  logic           exp_rst,
    rsa_core_exp_if.master bus
);
    localparam int DW = DATA_WIDTH;
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(DW - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_RED_REQ, S_RED_WAIT, S_SQ_REQ, S_SQ_WAIT,
        S_MUL_REQ, S_MUL_WAIT, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   base_q, base_d;
    logic [DW-1:0]   e_q, e_d;
    logic [DW-1:0]   n_q, n_d;
    logic [DW-1:0]   r_q, r_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   c_q, c_d;
    logic            err_q, err_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [2*DW-1:0] mod_a_q, mod_a_d;
    logic [DW-1:0]   mul_y;
    logic            to_err;

    always_ff @(posedge exp_clk) begin
        if (exp_rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            e_q     <= '0;
            n_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            mod_a_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            e_q     <= e_d;
            n_q     <= n_d;
            r_q     <= r_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            mod_a_q <= mod_a_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        e_d     = e_q;
        n_d     = n_q;
        r_d     = r_q;
        b_d     = b_q;
        c_d     = c_q;
        err_d   = err_q;
        idx_d   = idx_q;
        mod_a_d = mod_a_q;
        mul_y   = '0;
        to_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.exp_start == START) begin
                    base_d  = bus.exp_base;
                    e_d     = bus.exp_e;
                    n_d     = bus.exp_n;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (n_q == '0) begin
                    to_err = 1'b1;
                end else begin
                    // x mod 1 is always 0, so the accumulator must start there too
                    r_d     = (n_q == DW'(1)) ? '0 : DW'(1);
                    idx_d   = IDX_TOP;
                    mod_a_d = {{DW{1'b0}}, base_q};
                    state_d = S_RED_REQ;
                end
            end
            S_RED_REQ: state_d = S_RED_WAIT;
            S_RED_WAIT: begin
                if (bus.mod_done) begin
                    if (bus.mod_err) begin
                        to_err = 1'b1;
                    end else begin
                        b_d     = bus.mod_c;
                        state_d = S_SQ_REQ;
                    end
                end
            end
            S_SQ_REQ: state_d = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (bus.mod_done) begin
                    if (bus.mod_err) begin
                        to_err = 1'b1;
                    end else begin
                        r_d     = bus.mod_c;
                        state_d = e_q[idx_q] ? S_MUL_REQ : S_NEXT;
                    end
                end
            end
            S_MUL_REQ: state_d = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (bus.mod_done) begin
                    if (bus.mod_err) begin
                        to_err = 1'b1;
                    end else begin
                        r_d     = bus.mod_c;
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    c_d     = r_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = S_SQ_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (to_err) begin
            state_d = S_ERROR;
            c_d     = '1;
            err_d   = 1'b1;
        end

        // Operand is registered on entry to a REQ state so mod_a holds until mod_done
        if (state_d == S_SQ_REQ || state_d == S_MUL_REQ) begin
            mul_y   = (state_d == S_MUL_REQ) ? b_d : r_d;
            mod_a_d = (2*DW)'(r_d) * (2*DW)'(mul_y);
        end
    end

    assign bus.exp_busy  = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign bus.exp_done  = (state_q == S_DONE) || (state_q == S_ERROR);
    assign bus.exp_err   = err_q;
    assign bus.exp_c     = c_q;
    assign bus.mod_start = state_q inside {S_RED_REQ, S_SQ_REQ, S_MUL_REQ};
    assign bus.mod_a     = mod_a_q;
    assign bus.mod_b     = n_q;
endmodule

// File: tb/tb_rsa_core_exp.sv
// Bench for rsa_core_exp: random-latency mod responder plus an
// arithmetic reference model (repeated multiplication mod N).
module tb_rsa_core_exp;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rsa_core_exp_if #(.DATA_WIDTH(DW)) bus_if ();

    rsa_core_exp #(.DATA_WIDTH(DW), .START(1'b1)) dut (
        .exp_clk (clk),
        .exp_rst (rst),
        .bus     (bus_if)
    );

    int checks = 0;
    int passes = 0;

    // mod responder state
    logic          r_done = 1'b0;
    logic          r_err  = 1'b0;
    logic [DW-1:0] r_c    = '0;
    int req_cnt = 0, stab_err = 0, overlap_err = 0;
    int lat_min = 1, lat_max = 20, lat_force = 0, err_target = -1;
    bit spurious_en = 1'b0;
    bit pending = 1'b0, orphan = 1'b0, spur_next = 1'b0;
    int lat_left = 0, cur_req = 0;
    logic [2*DW-1:0] a_lat = '0;
    logic [DW-1:0]   b_lat = '0;

    assign bus_if.mod_done = r_done;
    assign bus_if.mod_err  = r_err;
    assign bus_if.mod_c    = r_c;

    always @(negedge clk) begin
        r_done = 1'b0;
        r_err  = 1'b0;
        if (rst && pending) orphan = 1'b1;
        if (spur_next) begin
            spur_next = 1'b0;
            r_done = 1'b1;
            r_err  = 1'($urandom_range(0, 1));
            r_c    = DW'($urandom);
        end
        if (bus_if.mod_start === 1'b1) begin
            req_cnt++;
            if (pending) overlap_err++;
            pending  = 1'b1;
            orphan   = 1'b0;
            cur_req  = req_cnt;
            a_lat    = bus_if.mod_a;
            b_lat    = bus_if.mod_b;
            lat_left = (lat_force != 0) ? lat_force : int'($urandom_range(lat_min, lat_max));
        end else if (pending) begin
            if (!orphan && bus_if.mod_a !== a_lat) stab_err++;
            lat_left--;
            if (lat_left == 0) begin
                pending = 1'b0;
                r_done  = 1'b1;
                r_err   = (cur_req == err_target) || (b_lat == '0);
                r_c     = (b_lat == '0) ? '0 : DW'(a_lat % (2*DW)'(b_lat));
                spur_next = spurious_en;
            end
        end
    end

    function automatic void ref_exp(input logic [DW-1:0] b, input logic [DW-1:0] e,
                                    input logic [DW-1:0] n, output logic [DW-1:0] c,
                                    output logic err);
        longint r;
        if (n == '0) begin
            c = '1;
            err = 1'b1;
            return;
        end
        r = longint'(1) % longint'(n);
        for (int k = 0; k < int'(e); k++) r = (r * longint'(b)) % longint'(n);
        c = DW'(r);
        err = 1'b0;
    endfunction

    task automatic run_op(input logic [DW-1:0] b, input logic [DW-1:0] e, input logic [DW-1:0] n,
                          input bit hold, output logic [DW-1:0] c, output logic err,
                          output int nreq, output int lat, output logic busy_at_done,
                          output bit tmo);
        int r0;
        @(negedge clk);
        bus_if.exp_base  = b;
        bus_if.exp_e     = e;
        bus_if.exp_n     = n;
        bus_if.exp_start = 1'b1;
        r0 = req_cnt;
        @(negedge clk);
        if (!hold) begin
            bus_if.exp_start = 1'b0;
            bus_if.exp_base  = DW'($urandom);
            bus_if.exp_e     = DW'($urandom);
            bus_if.exp_n     = DW'($urandom);
        end
        lat = 1;
        tmo = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (bus_if.exp_done === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
            lat++;
        end
        c            = bus_if.exp_c;
        err          = bus_if.exp_err;
        busy_at_done = bus_if.exp_busy;
        nreq         = req_cnt - r0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ((|{bus_if.exp_busy, bus_if.exp_done, bus_if.exp_err, bus_if.mod_start,
               bus_if.exp_c, bus_if.mod_a, bus_if.mod_b}) !== 1'b0)
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b c=%h ms=%b a=%h b=%h want all zero",
                     bus_if.exp_busy, bus_if.exp_done, bus_if.exp_err, bus_if.exp_c,
                     bus_if.mod_start, bus_if.mod_a, bus_if.mod_b);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [DW-1:0] c; logic err, bz; int nreq, lat; bit tmo;
        run_op(8'd3, 8'd5, 8'd7, 1'b0, c, err, nreq, lat, bz, tmo);
        checks++; if (tmo) $display("FAIL basic_timeout: no exp_done"); else passes++;
        checks++; if (c !== 8'd5) $display("FAIL basic_c: got %0d want 5", c); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else passes++;
        checks++; if (nreq != 11) $display("FAIL basic_nreq: got %0d want 11", nreq); else passes++;
        checks++; if (bz !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", bz); else passes++;
        checks++; if (bus_if.mod_b !== 8'd7) $display("FAIL basic_mod_b: got %0d want 7", bus_if.mod_b); else passes++;
        @(negedge clk);
        checks++; if (bus_if.exp_done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", bus_if.exp_done); else passes++;
        checks++; if (bus_if.exp_c !== 8'd5) $display("FAIL c_held: got %0d want 5", bus_if.exp_c); else passes++;

        run_op(8'd2, 8'd10, 8'd255, 1'b0, c, err, nreq, lat, bz, tmo);
        checks++; if (tmo || c !== 8'd4 || err !== 1'b0) $display("FAIL pow2_c: got c=%0d err=%b tmo=%0d want c=4 err=0", c, err, tmo); else passes++;
        checks++; if (nreq != 11) $display("FAIL pow2_nreq: got %0d want 11", nreq); else passes++;

        run_op(8'd200, 8'd0, 8'd13, 1'b0, c, err, nreq, lat, bz, tmo);
        checks++; if (tmo || c !== 8'd1 || err !== 1'b0) $display("FAIL e0_c: got c=%0d err=%b tmo=%0d want c=1 err=0", c, err, tmo); else passes++;
        checks++; if (nreq != 9) $display("FAIL e0_nreq: got %0d want 9", nreq); else passes++;
        checks++; if (stab_err != 0 || overlap_err != 0) $display("FAIL basic_protocol: got stab=%0d overlap=%0d want 0/0", stab_err, overlap_err); else passes++;
    endtask

    task automatic test_n_zero();
        logic [DW-1:0] c; logic err, bz; int nreq, lat; bit tmo;
        run_op(8'd9, 8'd3, 8'd0, 1'b0, c, err, nreq, lat, bz, tmo);
        checks++; if (tmo || lat != 2) $display("FAIL nzero_latency: got %0d want 2", lat); else passes++;
        checks++; if (err !== 1'b1 || c !== 8'hFF) $display("FAIL nzero_result: got c=%h err=%b want c=ff err=1", c, err); else passes++;
        checks++; if (nreq != 0) $display("FAIL nzero_nreq: got %0d want 0", nreq); else passes++;
        checks++; if (bz !== 1'b0) $display("FAIL nzero_busy: got %b want 0", bz); else passes++;
    endtask

    task automatic test_n_one();
        logic [DW-1:0] c; logic err, bz; int nreq, lat; bit tmo;
        run_op(8'd77, 8'd200, 8'd1, 1'b0, c, err, nreq, lat, bz, tmo);
        checks++; if (tmo || c !== 8'd0 || err !== 1'b0) $display("FAIL none_result: got c=%0d err=%b want c=0 err=0", c, err); else passes++;
        checks++; if (nreq != 12) $display("FAIL none_nreq: got %0d want 12", nreq); else passes++;
    endtask

    task automatic test_mod_err();
        logic [DW-1:0] c; logic err, bz; int nreq, lat, after; bit tmo;
        err_target = req_cnt + 4;
        run_op(8'd3, 8'd5, 8'd7, 1'b0, c, err, nreq, lat, bz, tmo);
        checks++; if (tmo || err !== 1'b1 || c !== 8'hFF) $display("FAIL moderr_result: got c=%h err=%b want c=ff err=1", c, err); else passes++;
        checks++; if (nreq != 4) $display("FAIL moderr_nreq: got %0d want 4", nreq); else passes++;
        after = req_cnt;
        repeat (30) @(negedge clk);
        checks++; if (req_cnt != after) $display("FAIL moderr_no_more_req: got %0d want %0d", req_cnt, after); else passes++;
        checks++; if (bus_if.exp_err !== 1'b1 || bus_if.exp_c !== 8'hFF) $display("FAIL moderr_held: got c=%h err=%b want c=ff err=1", bus_if.exp_c, bus_if.exp_err); else passes++;
        err_target = -1;
    endtask

    task automatic test_reset_mid_op();
        logic [DW-1:0] c; logic err, bz; int nreq, lat, r0, starts, bad_done, bad_out; bit tmo, seen;
        lat_force = 12;
        bad_done = 0;
        bad_out  = 0;
        @(negedge clk);
        bus_if.exp_base = 8'd3; bus_if.exp_e = 8'd5; bus_if.exp_n = 8'd7; bus_if.exp_start = 1'b1;
        r0 = req_cnt;
        @(negedge clk);
        bus_if.exp_start = 1'b0;
        checks++; if (bus_if.exp_err !== 1'b0) $display("FAIL err_clear_on_start: got %b want 0", bus_if.exp_err); else passes++;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (req_cnt >= r0 + 2) seen = 1'b1;
        end
        checks++; if (!seen) $display("FAIL rstmid_reach_sq: got %0d requests want 2", req_cnt - r0); else passes++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        starts = req_cnt;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_if.exp_done !== 1'b0) bad_done++;
            if ((|{bus_if.exp_busy, bus_if.exp_err, bus_if.mod_start, bus_if.exp_c,
                   bus_if.mod_a, bus_if.mod_b}) !== 1'b0) bad_out++;
        end
        checks++; if (bad_done != 0) $display("FAIL rstmid_no_done: got %0d done cycles want 0", bad_done); else passes++;
        checks++; if (bad_out != 0) $display("FAIL rstmid_outputs_zero: got %0d nonzero cycles want 0", bad_out); else passes++;
        checks++; if (req_cnt != starts || pending) $display("FAIL rstmid_idle: got reqs=%0d pending=%0d want reqs=%0d pending=0", req_cnt, pending, starts); else passes++;
        lat_force = 0;
        run_op(8'd3, 8'd5, 8'd7, 1'b0, c, err, nreq, lat, bz, tmo);
        checks++; if (tmo || c !== 8'd5 || err !== 1'b0 || nreq != 11) $display("FAIL rstmid_rerun: got c=%0d err=%b nreq=%0d want c=5 err=0 nreq=11", c, err, nreq); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] c; logic err, bz; int nreq, lat, r0; bit tmo;
        run_op(8'd3, 8'd5, 8'd7, 1'b1, c, err, nreq, lat, bz, tmo);
        checks++; if (tmo || c !== 8'd5 || nreq != 11) $display("FAIL b2b_first: got c=%0d nreq=%0d want c=5 nreq=11", c, nreq); else passes++;
        @(negedge clk);
        bus_if.exp_base = 8'd2; bus_if.exp_e = 8'd10; bus_if.exp_n = 8'd255;
        @(negedge clk);
        checks++; if (bus_if.exp_busy !== 1'b1) $display("FAIL b2b_restart: got busy=%b want 1", bus_if.exp_busy); else passes++;
        bus_if.exp_start = 1'b0;
        r0 = req_cnt;
        tmo = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (bus_if.exp_done === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++; if (tmo || bus_if.exp_c !== 8'd4 || (req_cnt - r0) != 11) $display("FAIL b2b_second: got c=%0d nreq=%0d tmo=%0d want c=4 nreq=11", bus_if.exp_c, req_cnt - r0, tmo); else passes++;
    endtask

    task automatic test_random();
        logic [DW-1:0] b, e, n, c, wc; logic err, werr, bz; int nreq, lat, bad; bit tmo;
        spurious_en = 1'b1;
        lat_max = 3;
        bad = 0;
        for (int v = 0; v < 500; v++) begin
            b = DW'($urandom);
            e = DW'($urandom);
            n = DW'($urandom_range(1, 255));
            ref_exp(b, e, n, wc, werr);
            run_op(b, e, n, 1'b0, c, err, nreq, lat, bz, tmo);
            checks++;
            if (tmo || c !== wc || err !== werr) begin
                $display("FAIL rand_result: base=%0d e=%0d n=%0d got c=%0d err=%b want c=%0d err=%b", b, e, n, c, err, wc, werr);
                bad++;
            end else passes++;
            checks++;
            if (nreq != 1 + DW + $countones(e)) begin
                $display("FAIL rand_nreq: e=%0d got %0d want %0d", e, nreq, 1 + DW + $countones(e));
                bad++;
            end else passes++;
            if (bad > 20) break;
        end
        spurious_en = 1'b0;
        lat_max = 20;
        checks++; if (stab_err != 0 || overlap_err != 0) $display("FAIL rand_protocol: got stab=%0d overlap=%0d want 0/0", stab_err, overlap_err); else passes++;
    endtask

    initial begin
        bus_if.exp_start = 1'b0;
        bus_if.exp_base  = '0;
        bus_if.exp_e     = '0;
        bus_if.exp_n     = '0;
        test_reset();
        test_basic();
        test_n_zero();
        test_n_one();
        test_mod_err();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
